// File: rtl/asap_mon_pkg.sv
// rtl/asap_mon_pkg.sv - shared state encoding and cause bit indices for the exec monitor
package asap_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } mon_state_e;

    localparam int NCAUSE      = 7;
    localparam int C_ILL_ENTRY = 0;
    localparam int C_ILL_EXIT  = 1;
    localparam int C_IRQ       = 2;
    localparam int C_ER_WR     = 3;
    localparam int C_DMA_ER    = 4;
    localparam int C_OR_WR     = 5;
    localparam int C_DMA_OR    = 6;

endpackage

// File: rtl/asap_exec_channel.sv
// rtl/asap_exec_channel.sv - one ER/OR proof-of-execution channel
// Holds its FSM, a bound snapshot taken on RUN entry, sticky causes and a saturating abort counter.
module asap_exec_channel
    import asap_mon_pkg::*;
#(
    parameter int AW          = 16,
    parameter int CNT_W       = 8,
    parameter int IRQ_ALLOWED = 0
) (
    input  logic              clk_i,
    input  logic              puc_i,
    input  logic [AW-1:0]     pc_i,
    input  logic [AW-1:0]     pc_prev_i,
    input  logic              data_en_i,
    input  logic              data_wr_i,
    input  logic [AW-1:0]     data_addr_i,
    input  logic              dma_en_i,
    input  logic [AW-1:0]     dma_addr_i,
    input  logic              irq_i,
    input  logic [AW-1:0]     er_min_i,
    input  logic [AW-1:0]     er_max_i,
    input  logic [AW-1:0]     or_min_i,
    input  logic [AW-1:0]     or_max_i,
    output logic              exec_o,
    output logic [NCAUSE-1:0] cause_o,
    output logic [CNT_W-1:0]  viol_cnt_o,
    output logic              abort_o
);

    mon_state_e        state_q;
    logic              exec_q;
    logic              abort_q;
    logic [NCAUSE-1:0] cause_q;
    logic [NCAUSE-1:0] cause_now;
    logic [NCAUSE-1:0] cause_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [AW-1:0]     er_min_q;
    logic [AW-1:0]     er_max_q;
    logic [AW-1:0]     or_min_q;
    logic [AW-1:0]     or_max_q;

    logic enabled;
    logic pc_in_er;
    logic prev_in_er;
    logic run_st;
    logic live_st;
    logic bounds_moved;
    logic violation;
    logic start_hit;
    logic exit_ok;

    function automatic logic in_rng(input logic [AW-1:0] a, input logic [AW-1:0] lo,
                                    input logic [AW-1:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    assign enabled    = (er_min_i <= er_max_i) && (or_min_i <= or_max_i);
    assign pc_in_er   = in_rng(pc_i, er_min_i, er_max_i);
    assign prev_in_er = in_rng(pc_prev_i, er_min_i, er_max_i);
    assign run_st     = (state_q == ST_RUN);
    assign live_st    = (state_q == ST_RUN) || (state_q == ST_DONE);

    // Bounds rewritten while a proof is live would let code slip in unnoticed; treat as an exit violation.
    assign bounds_moved = live_st &&
        ({er_min_q, er_max_q, or_min_q, or_max_q} != {er_min_i, er_max_i, or_min_i, or_max_i});

    always_comb begin
        cause_now              = '0;
        cause_now[C_ILL_ENTRY] = (pc_i > er_min_i) && (pc_i <= er_max_i) && !prev_in_er;
        cause_now[C_ILL_EXIT]  = (run_st && !pc_in_er && (pc_prev_i != er_max_i)) || bounds_moved;
        cause_now[C_IRQ]       = run_st && irq_i && (IRQ_ALLOWED == 0);
        cause_now[C_ER_WR]     = data_en_i && data_wr_i && in_rng(data_addr_i, er_min_i, er_max_i);
        cause_now[C_DMA_ER]    = dma_en_i && in_rng(dma_addr_i, er_min_i, er_max_i);
        cause_now[C_OR_WR]     = data_en_i && data_wr_i && in_rng(data_addr_i, or_min_i, or_max_i)
                                 && !pc_in_er;
        cause_now[C_DMA_OR]    = dma_en_i && in_rng(dma_addr_i, or_min_i, or_max_i);
    end

    assign violation = |cause_now;
    assign cause_d   = cause_q | cause_now;
    assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign start_hit = !violation && (pc_i == er_min_i);
    assign exit_ok   = !pc_in_er && (pc_prev_i == er_max_i);

    always_ff @(posedge clk_i) begin
        if (puc_i) begin
            state_q  <= ST_IDLE;
            exec_q   <= 1'b0;
            abort_q  <= 1'b0;
            cause_q  <= '0;
            cnt_q    <= '0;
            er_min_q <= '0;
            er_max_q <= '0;
            or_min_q <= '0;
            or_max_q <= '0;
        end else if (!enabled) begin
            state_q <= ST_IDLE;
            exec_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            cause_q <= cause_d;
            case (state_q)
                ST_IDLE: begin
                    if (start_hit) begin
                        state_q  <= ST_RUN;
                        exec_q   <= 1'b1;
                        cause_q  <= '0;
                        er_min_q <= er_min_i;
                        er_max_q <= er_max_i;
                        or_min_q <= or_min_i;
                        or_max_q <= or_max_i;
                    end
                end
                ST_RUN, ST_DONE: begin
                    if (violation) begin
                        state_q <= ST_ABORT;
                        exec_q  <= 1'b0;
                        abort_q <= 1'b1;
                        cnt_q   <= cnt_d;
                    end else if (run_st && exit_ok) begin
                        state_q <= ST_DONE;
                    end else if (!run_st && (pc_i == er_min_i)) begin
                        state_q  <= ST_RUN;
                        cause_q  <= '0;
                        er_min_q <= er_min_i;
                        er_max_q <= er_max_i;
                        or_min_q <= or_min_i;
                        or_max_q <= or_max_i;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    exec_q  <= 1'b0;
                end
            endcase
        end
    end

    assign exec_o     = exec_q;
    assign cause_o    = cause_q;
    assign viol_cnt_o = cnt_q;
    assign abort_o    = abort_q;

endmodule

// File: rtl/asap_exec_monitor.sv
// rtl/asap_exec_monitor.sv - multi-channel ER/OR execution monitor top
// Registers the shared pc_prev, slices the packed bound buses per channel and merges abort pulses.
module asap_exec_monitor
    import asap_mon_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int AW          = 16,
    parameter int IRQ_ALLOWED = 0,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    puc,
    input  logic [AW-1:0]           pc,
    input  logic                    data_en,
    input  logic                    data_wr,
    input  logic [AW-1:0]           data_addr,
    input  logic                    dma_en,
    input  logic [AW-1:0]           dma_addr,
    input  logic                    irq,
    input  logic [NCH*AW-1:0]       er_min,
    input  logic [NCH*AW-1:0]       er_max,
    input  logic [NCH*AW-1:0]       or_min,
    input  logic [NCH*AW-1:0]       or_max,
    output logic [NCH-1:0]          exec,
    output logic [NCH*NCAUSE-1:0]   cause,
    output logic [NCH*CNT_W-1:0]    viol_cnt,
    output logic                    any_abort
);

    logic [AW-1:0]  pc_prev_q;
    logic [NCH-1:0] abort_vec;

    always_ff @(posedge clk) begin
        if (puc) begin
            pc_prev_q <= '0;
        end else begin
            pc_prev_q <= pc;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        asap_exec_channel #(
            .AW          (AW),
            .CNT_W       (CNT_W),
            .IRQ_ALLOWED (IRQ_ALLOWED)
        ) u_ch (
            .clk_i       (clk),
            .puc_i       (puc),
            .pc_i        (pc),
            .pc_prev_i   (pc_prev_q),
            .data_en_i   (data_en),
            .data_wr_i   (data_wr),
            .data_addr_i (data_addr),
            .dma_en_i    (dma_en),
            .dma_addr_i  (dma_addr),
            .irq_i       (irq),
            .er_min_i    (er_min[g*AW +: AW]),
            .er_max_i    (er_max[g*AW +: AW]),
            .or_min_i    (or_min[g*AW +: AW]),
            .or_max_i    (or_max[g*AW +: AW]),
            .exec_o      (exec[g]),
            .cause_o     (cause[g*NCAUSE +: NCAUSE]),
            .viol_cnt_o  (viol_cnt[g*CNT_W +: CNT_W]),
            .abort_o     (abort_vec[g])
        );
    end

    assign any_abort = |abort_vec;

endmodule

// File: tb/tb_asap_exec_monitor.sv
// tb/tb_asap_exec_monitor.sv - self-checking bench for asap_exec_monitor (strict and irq-tolerant builds)
module tb_asap_exec_monitor;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DONE  = 2;
    localparam int P_ABORT = 3;
    localparam int CNT_MAX = 3;

    logic        clk = 1'b0;
    logic        puc;
    logic [15:0] pc;
    logic        data_en, data_wr, dma_en, irq;
    logic [15:0] data_addr, dma_addr;
    logic [31:0] er_min, er_max, or_min, or_max;

    logic [1:0]  exec_v  [2];
    logic [13:0] cause_v [2];
    logic [3:0]  cnt_v   [2];
    logic [1:0]  abort_v;

    int checks = 0;
    int errors = 0;

    int          ph     [2][2];
    logic [6:0]  mcause [2][2];
    int          mcnt   [2][2];
    logic [63:0] snap   [2][2];
    logic [15:0] mprev;

    always #5 clk = ~clk;

    asap_exec_monitor #(.NCH(2), .AW(16), .IRQ_ALLOWED(0), .CNT_W(2)) u_dut_strict (
        .clk(clk), .puc(puc), .pc(pc), .data_en(data_en), .data_wr(data_wr),
        .data_addr(data_addr), .dma_en(dma_en), .dma_addr(dma_addr), .irq(irq),
        .er_min(er_min), .er_max(er_max), .or_min(or_min), .or_max(or_max),
        .exec(exec_v[0]), .cause(cause_v[0]), .viol_cnt(cnt_v[0]), .any_abort(abort_v[0])
    );

    asap_exec_monitor #(.NCH(2), .AW(16), .IRQ_ALLOWED(1), .CNT_W(2)) u_dut_irq_ok (
        .clk(clk), .puc(puc), .pc(pc), .data_en(data_en), .data_wr(data_wr),
        .data_addr(data_addr), .dma_en(dma_en), .dma_addr(dma_addr), .irq(irq),
        .er_min(er_min), .er_max(er_max), .or_min(or_min), .or_max(or_max),
        .exec(exec_v[1]), .cause(cause_v[1]), .viol_cnt(cnt_v[1]), .any_abort(abort_v[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit inr(input logic [15:0] a, input logic [15:0] lo, input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    // Reference model: violation rules evaluated directly on the bus values of one cycle.
    function automatic logic [6:0] model_causes(input int u, input int ch);
        logic [15:0] lo, hi, olo, ohi;
        logic [6:0]  c;
        bit          live;
        lo   = er_min[ch*16 +: 16];
        hi   = er_max[ch*16 +: 16];
        olo  = or_min[ch*16 +: 16];
        ohi  = or_max[ch*16 +: 16];
        live = (ph[u][ch] == P_RUN) || (ph[u][ch] == P_DONE);
        c    = '0;
        c[0] = (pc > lo) && (pc <= hi) && !inr(mprev, lo, hi);
        c[1] = ((ph[u][ch] == P_RUN) && !inr(pc, lo, hi) && (mprev != hi)) ||
               (live && (snap[u][ch] != {lo, hi, olo, ohi}));
        c[2] = (ph[u][ch] == P_RUN) && irq && (u == 0);
        c[3] = data_en && data_wr && inr(data_addr, lo, hi);
        c[4] = dma_en && inr(dma_addr, lo, hi);
        c[5] = data_en && data_wr && inr(data_addr, olo, ohi) && !inr(pc, lo, hi);
        c[6] = dma_en && inr(dma_addr, olo, ohi);
        return c;
    endfunction

    task automatic model_step();
        for (int u = 0; u < 2; u++) begin
            for (int ch = 0; ch < 2; ch++) begin
                logic [15:0] lo, hi, olo, ohi;
                logic [6:0]  v;
                lo  = er_min[ch*16 +: 16];
                hi  = er_max[ch*16 +: 16];
                olo = or_min[ch*16 +: 16];
                ohi = or_max[ch*16 +: 16];
                if (puc) begin
                    ph[u][ch]     = P_IDLE;
                    mcause[u][ch] = '0;
                    mcnt[u][ch]   = 0;
                    snap[u][ch]   = '0;
                end else if (lo > hi || olo > ohi) begin
                    ph[u][ch] = P_IDLE;
                end else begin
                    v = model_causes(u, ch);
                    mcause[u][ch] = mcause[u][ch] | v;
                    if (ph[u][ch] == P_ABORT) begin
                        ph[u][ch] = P_IDLE;
                    end else if (v != 0) begin
                        if (ph[u][ch] != P_IDLE) begin
                            ph[u][ch] = P_ABORT;
                            if (mcnt[u][ch] < CNT_MAX) mcnt[u][ch]++;
                        end
                    end else if (ph[u][ch] == P_RUN) begin
                        if (!inr(pc, lo, hi) && mprev == hi) ph[u][ch] = P_DONE;
                    end else if (pc == lo) begin
                        ph[u][ch]     = P_RUN;
                        mcause[u][ch] = '0;
                        snap[u][ch]   = {lo, hi, olo, ohi};
                    end
                end
            end
        end
        mprev = puc ? 16'h0 : pc;
    endtask

    task automatic compare_all();
        for (int u = 0; u < 2; u++) begin
            logic [1:0]  e;
            logic [13:0] c;
            logic [3:0]  n;
            logic        a;
            a = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                e[ch]          = (ph[u][ch] == P_RUN) || (ph[u][ch] == P_DONE);
                c[ch*7 +: 7]   = mcause[u][ch];
                n[ch*2 +: 2]   = 2'(mcnt[u][ch]);
                a              = a | (ph[u][ch] == P_ABORT);
            end
            check_val($sformatf("exec[u%0d]", u), 32'(exec_v[u]), 32'(e));
            check_val($sformatf("cause[u%0d]", u), 32'(cause_v[u]), 32'(c));
            check_val($sformatf("viol_cnt[u%0d]", u), 32'(cnt_v[u]), 32'(n));
            check_val($sformatf("any_abort[u%0d]", u), 32'(abort_v[u]), 32'(a));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
        data_en = 1'b0;
        data_wr = 1'b0;
        dma_en  = 1'b0;
        irq     = 1'b0;
    endtask

    task automatic go(input logic [15:0] p);
        pc = p;
        tick();
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 16'hE000 + 16'($urandom_range(0, 16'hFE));
            1:       return 16'hE100 + 16'($urandom_range(0, 16'hFE));
            2:       return 16'h0400 + 16'($urandom_range(0, 16'h1F));
            3:       return 16'h0420 + 16'($urandom_range(0, 16'h1F));
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        puc = 1'b1; pc = '0; data_en = 0; data_wr = 0; data_addr = '0;
        dma_en = 0; dma_addr = '0; irq = 0;
        er_min = {16'hE100, 16'hE000};
        er_max = {16'hE1FE, 16'hE0FE};
        or_min = {16'h0420, 16'h0400};
        or_max = {16'h043F, 16'h041F};
        mprev = '0;
        for (int u = 0; u < 2; u++)
            for (int ch = 0; ch < 2; ch++) begin
                ph[u][ch] = P_IDLE; mcause[u][ch] = '0; mcnt[u][ch] = 0; snap[u][ch] = '0;
            end
        @(negedge clk);
        tick();
        tick();
        check_val("reset_exec", 32'(exec_v[0]), 32'd0);
        check_val("reset_cnt", 32'(cnt_v[0]), 32'd0);
        puc = 1'b0;

        // Legal run through ER0 and out
        go(16'h0000);
        go(16'hE000);
        check_val("legal_exec_run", 32'(exec_v[0][0]), 32'd1);
        go(16'hE002);
        go(16'hE0FE);
        go(16'hE200);
        check_val("legal_exec_done", 32'(exec_v[0][0]), 32'd1);
        check_val("legal_cause", 32'(cause_v[0][6:0]), 32'd0);
        check_val("legal_cnt", 32'(cnt_v[0][1:0]), 32'd0);

        // Entry into the middle of ER0 from idle
        puc = 1'b1; tick(); puc = 1'b0;
        go(16'hD000);
        go(16'hE010);
        check_val("mid_exec", 32'(exec_v[0][0]), 32'd0);
        check_val("mid_cause_bit0", 32'(cause_v[0][0]), 32'd1);
        check_val("mid_cnt", 32'(cnt_v[0][1:0]), 32'd0);
        check_val("mid_ch1_cause", 32'(cause_v[0][13:7]), 32'd0);

        // DMA into OR0 during RUN
        go(16'hD000);
        go(16'hE000);
        dma_en = 1'b1; dma_addr = 16'h0410;
        go(16'hE002);
        check_val("dma_abort", 32'(abort_v[0]), 32'd1);
        check_val("dma_cause_bit6", 32'(cause_v[0][6]), 32'd1);
        check_val("dma_cnt", 32'(cnt_v[0][1:0]), 32'd1);
        go(16'hE004);
        check_val("dma_idle_exec", 32'(exec_v[0][0]), 32'd0);
        check_val("dma_abort_gone", 32'(abort_v[0]), 32'd0);

        // IRQ during RUN: strict build aborts, tolerant build completes
        go(16'hD000);
        go(16'hE000);
        irq = 1'b1;
        go(16'hE002);
        check_val("irq_strict_exec", 32'(exec_v[0][0]), 32'd0);
        check_val("irq_strict_bit2", 32'(cause_v[0][2]), 32'd1);
        check_val("irq_ok_exec", 32'(exec_v[1][0]), 32'd1);
        go(16'hE0FE);
        go(16'hE300);
        check_val("irq_ok_done", 32'(exec_v[1][0]), 32'd1);

        // Counter saturation
        for (int k = 0; k < 5; k++) begin
            go(16'hD000);
            go(16'hE000);
            dma_en = 1'b1; dma_addr = 16'h0410;
            go(16'hE002);
            go(16'hD000);
        end
        check_val("sat_cnt_strict", 32'(cnt_v[0][1:0]), 32'd3);
        check_val("sat_cnt_irq_ok", 32'(cnt_v[1][1:0]), 32'd3);

        // Reset in the middle of a run
        go(16'hE000);
        puc = 1'b1;
        tick();
        for (int u = 0; u < 2; u++) begin
            check_val("puc_exec", 32'(exec_v[u]), 32'd0);
            check_val("puc_cause", 32'(cause_v[u]), 32'd0);
            check_val("puc_cnt", 32'(cnt_v[u]), 32'd0);
            check_val("puc_abort", 32'(abort_v[u]), 32'd0);
        end
        puc = 1'b0;

        // ER1 bound rewritten mid-run
        go(16'hD000);
        go(16'hE100);
        er_max[31:16] = 16'hE1F0;
        go(16'hE102);
        check_val("bounds_abort", 32'(abort_v[0]), 32'd1);
        check_val("bounds_bit1", 32'(cause_v[0][8]), 32'd1);
        er_max[31:16] = 16'hE1FE;
        go(16'hD000);

        // Disabled ER0 (min above max)
        er_min[15:0] = 16'hE100;
        er_max[15:0] = 16'hE000;
        go(16'hE100);
        check_val("disabled_exec", 32'(exec_v[0][0]), 32'd0);
        go(16'hE102);
        check_val("disabled_exec2", 32'(exec_v[0][0]), 32'd0);
        er_min[15:0] = 16'hE000;
        er_max[15:0] = 16'hE0FE;
        go(16'h0000);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 50)      pc = pc + 16'd2;
            else if (r < 60) pc = ($urandom_range(0, 1) == 0) ? 16'hE000 : 16'hE100;
            else if (r < 68) pc = ($urandom_range(0, 1) == 0) ? 16'hE0FE : er_max[31:16];
            else if (r < 85) pc = pick_addr();
            if ($urandom_range(0, 99) < 10) begin
                data_en = 1'b1; data_wr = 1'($urandom_range(0, 1)); data_addr = pick_addr();
            end
            if ($urandom_range(0, 99) < 8) begin
                dma_en = 1'b1; dma_addr = pick_addr();
            end
            irq = ($urandom_range(0, 99) < 5);
            puc = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 2))
                    0:       er_max[31:16] = 16'hE1FE;
                    1:       er_max[31:16] = 16'hE1F0;
                    default: er_max[31:16] = 16'hE0F0;
                endcase
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
